// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard/stall sequencer for a 5-stage MIPS pipeline.
// Resolves load-use, taken-branch redirect and HI/LO (mult/div busy) hazards.
//
// Parameters:
//   MD_LATENCY  cycles the mult/div unit stays busy after issue (1..63)
//   CNT_W       width of the saturating stall counter
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous active-low reset (0 = reset)
//   id_rs, id_rt     source register fields of the ID instruction
//   id_uses_rs/rt    ID instruction actually reads rs / rt
//   id_uses_hilo     ID instruction touches HI/LO (incl. mult/div)
//   id_muldiv        ID instruction is mult/multu/div/divu
//   id_branch_taken  branch/jump in ID redirects the PC this cycle
//   ex_memread       EX instruction is a load
//   ex_rt            load destination register in EX
//   PC_write         PC update enable
//   Write_IF2ID      IF/ID load enable
//   flush_IF2ID      replace IF/ID instruction with NOP
//   flush_ID2EX      insert bubble into ID/EX
//   md_start         one-cycle mult/div issue pulse
//   md_busy          mult/div unit busy (registered)
//   stall_count      saturating count of stall cycles since reset

module pipe_hazard_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_uses_hilo,
    input  logic             id_muldiv,
    input  logic             id_branch_taken,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    output logic             PC_write,
    output logic             Write_IF2ID,
    output logic             flush_IF2ID,
    output logic             flush_ID2EX,
    output logic             md_start,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [5:0] MD_LAT6 = 6'(MD_LATENCY);

    state_t             state_q, state_d;
    logic [5:0]         md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;

    logic rs_match;
    logic rt_match;
    logic lu_hz;
    logic md_hz;
    logic stall;

    // ------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------
    always_comb begin
        rs_match = id_uses_rs && (ex_rt == id_rs);
        rt_match = id_uses_rt && (ex_rt == id_rt);
        // r0 is never a real dependency
        lu_hz    = ex_memread && (ex_rt != 5'd0) && (rs_match || rt_match);
        md_hz    = (state_q == MD_BUSY) && id_uses_hilo;
        stall    = lu_hz || md_hz;
    end

    // ------------------------------------------------------------
    // Pipeline control outputs
    // ------------------------------------------------------------
    always_comb begin
        PC_write    = 1'b0;
        Write_IF2ID = 1'b0;
        flush_IF2ID = 1'b0;
        flush_ID2EX = 1'b0;
        md_start    = 1'b0;
        if (reset) begin
            PC_write    = ~stall;
            Write_IF2ID = ~stall;
            flush_ID2EX = stall;
            // branch operands may be stale under a stall; it is
            // re-evaluated once the stall clears
            flush_IF2ID = id_branch_taken && !stall;
            md_start    = id_muldiv && !stall;
        end
    end

    assign md_busy     = (state_q == MD_BUSY);
    assign stall_count = stall_count_q;

    // ------------------------------------------------------------
    // Mult/div busy sequencer
    // ------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        unique case (state_q)
            RUN: begin
                if (md_start) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = MD_LAT6;
                end
            end
            MD_BUSY: begin
                md_cnt_d = md_cnt_q - 6'd1;
                // <= 1 also recovers from an out-of-range count
                if (md_cnt_q <= 6'd1) begin
                    state_d  = RUN;
                    md_cnt_d = 6'd0;
                end
            end
            default: begin
                state_d  = RUN;
                md_cnt_d = 6'd0;
            end
        endcase
    end

    // ------------------------------------------------------------
    // Saturating stall counter
    // ------------------------------------------------------------
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= RUN;
            md_cnt_q      <= 6'd0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            md_cnt_q      <= md_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: self-checking bench for pipe_hazard_ctrl.
// Two instances (latency 4 / width 4 and latency 32 / width 16) share stimulus.

module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rs, id_uses_rt, id_uses_hilo, id_muldiv;
    logic       id_branch_taken, ex_memread;

    logic        a_pcw, a_wr, a_fif, a_fid, a_mds, a_busy;
    logic [3:0]  a_cnt;
    logic        b_pcw, b_wr, b_fif, b_fid, b_mds, b_busy;
    logic [15:0] b_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) u_a (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_uses_hilo(id_uses_hilo), .id_muldiv(id_muldiv),
        .id_branch_taken(id_branch_taken),
        .ex_memread(ex_memread), .ex_rt(ex_rt),
        .PC_write(a_pcw), .Write_IF2ID(a_wr),
        .flush_IF2ID(a_fif), .flush_ID2EX(a_fid),
        .md_start(a_mds), .md_busy(a_busy), .stall_count(a_cnt)
    );

    pipe_hazard_ctrl #(.MD_LATENCY(32), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_uses_hilo(id_uses_hilo), .id_muldiv(id_muldiv),
        .id_branch_taken(id_branch_taken),
        .ex_memread(ex_memread), .ex_rt(ex_rt),
        .PC_write(b_pcw), .Write_IF2ID(b_wr),
        .flush_IF2ID(b_fif), .flush_ID2EX(b_fid),
        .md_start(b_mds), .md_busy(b_busy), .stall_count(b_cnt)
    );

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // busy window expressed as: issued at cycle iss -> busy for cycles
    // iss+1 .. iss+lat
    int  lat [2] = '{4, 32};
    int  cmax[2] = '{15, 65535};
    int  cyc = 0;
    bit  issued[2];
    int  iss[2];
    int  cnt[2];

    function automatic bit m_busy(int i);
        return issued[i] && (cyc > iss[i]) && (cyc <= iss[i] + lat[i]);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            bit lu, st, bz, e_pcw, e_fif, e_fid, e_mds;
            logic [31:0] act [2][7];
            act[0] = '{a_pcw, a_wr, a_fif, a_fid, a_mds, a_busy, 32'(a_cnt)};
            act[1] = '{b_pcw, b_wr, b_fif, b_fid, b_mds, b_busy, 32'(b_cnt)};
            lu = ex_memread && ex_rt != 0 &&
                 ((id_uses_rs && ex_rt == id_rs) ||
                  (id_uses_rt && ex_rt == id_rt));
            for (int i = 0; i < 2; i++) begin
                bz    = m_busy(i);
                st    = lu || (bz && id_uses_hilo);
                e_pcw = reset && !st;
                e_fid = reset && st;
                e_fif = reset && !st && id_branch_taken;
                e_mds = reset && !st && id_muldiv;
                chk($sformatf("m%0d.PC_write", i),    act[i][0], 32'(e_pcw));
                chk($sformatf("m%0d.Write_IF2ID", i), act[i][1], 32'(e_pcw));
                chk($sformatf("m%0d.flush_IF2ID", i), act[i][2], 32'(e_fif));
                chk($sformatf("m%0d.flush_ID2EX", i), act[i][3], 32'(e_fid));
                chk($sformatf("m%0d.md_start", i),    act[i][4], 32'(e_mds));
                chk($sformatf("m%0d.md_busy", i),     act[i][5], 32'(bz));
                chk($sformatf("m%0d.stall_count", i), act[i][6], 32'(cnt[i]));
                if (!reset) begin
                    issued[i] = 0;
                    cnt[i]    = 0;
                end else begin
                    if (st && cnt[i] < cmax[i]) cnt[i]++;
                    if (e_mds && !bz) begin
                        issued[i] = 1;
                        iss[i]    = cyc;
                    end
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic cyc_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_rt = 0;
        id_uses_rs = 0; id_uses_rt = 0; id_uses_hilo = 0;
        id_muldiv = 0; id_branch_taken = 0; ex_memread = 0;
    endtask

    task automatic load_use(input logic [4:0] r);
        ex_memread = 1; ex_rt = r; id_rs = 8; id_uses_rs = 1;
    endtask

    initial begin
        reset = 0;
        idle();
        cyc_step();
        chk("reset_pcw", a_pcw, 0);
        chk("reset_busy", a_busy, 0);
        chk("reset_cnt", b_cnt, 0);
        chk_en = 1;
        cyc_step();
        reset = 1;

        // load-use on rs
        load_use(8);
        #1;
        chk("lu_pcw", a_pcw, 0);
        chk("lu_wr", b_wr, 0);
        chk("lu_fid", a_fid, 1);
        cyc_step();
        idle();
        #1;
        chk("lu_cnt", b_cnt, 1);
        chk("lu_clear", b_pcw, 1);
        // ex_rt = 0 never stalls
        load_use(0);
        id_rs = 0;
        #1;
        chk("lu_r0", a_pcw, 1);
        cyc_step();
        // rt path, then rt not used
        idle();
        ex_memread = 1; ex_rt = 9; id_rt = 9; id_uses_rt = 1;
        #1;
        chk("lu_rt", a_fid, 1);
        cyc_step();
        id_uses_rt = 0;
        cyc_step();
        chk("lu_rt_cnt", b_cnt, 2);

        // taken branch, no hazard
        idle();
        id_branch_taken = 1;
        #1;
        chk("br_fif", a_fif, 1);
        chk("br_pcw", b_pcw, 1);
        cyc_step();
        chk("br_cnt", b_cnt, 2);

        // branch under load-use, then re-evaluated
        load_use(8);
        #1;
        chk("brlu_fif", a_fif, 0);
        chk("brlu_fid", b_fid, 1);
        cyc_step();
        ex_memread = 0;
        #1;
        chk("brlu_next_fif", a_fif, 1);
        cyc_step();

        // mult then mflo
        idle();
        reset = 0;
        cyc_step();
        reset = 1;
        id_muldiv = 1; id_uses_hilo = 1;
        #1;
        chk("mult_start", a_mds, 1);
        cyc_step();
        id_muldiv = 0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk($sformatf("mflo_busy%0d", k), a_busy, 1);
            chk($sformatf("mflo_stall%0d", k), a_pcw, 0);
            cyc_step();
        end
        #1;
        chk("mflo_issue_busy", a_busy, 0);
        chk("mflo_issue_pcw", a_pcw, 1);
        chk("mflo_cnt", a_cnt, 4);
        chk("mflo_b_busy", b_busy, 1);
        cyc_step();
        // lu and md together on u_b: one stall
        load_use(8);
        cyc_step();
        idle();
        #1;
        chk("both_b_cnt", b_cnt, 6);
        chk("both_a_cnt", a_cnt, 5);
        begin
            int w = 0;
            while (b_busy && w < 40) begin
                cyc_step();
                w++;
            end
            chk("b_busy_timeout", 32'(b_busy), 0);
        end

        // reset mid-busy
        id_muldiv = 1; id_uses_hilo = 1;
        cyc_step();
        idle();
        cyc_step();
        reset = 0;
        cyc_step();
        chk("rst_b_busy", b_busy, 0);
        chk("rst_b_cnt", b_cnt, 0);
        chk("rst_a_busy", a_busy, 0);
        reset = 1;
        id_uses_hilo = 1;
        #1;
        chk("rst_hilo_pcw", b_pcw, 1);
        cyc_step();

        // saturation
        idle();
        load_use(8);
        for (int k = 0; k < 20; k++) cyc_step();
        chk("sat_a", a_cnt, 15);
        chk("sat_b", b_cnt, 20);
        idle();
        cyc_step();
        cyc_step();

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
